fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the synchronous instruction memory. It owns the PC and drives the memory address.
- It pairs each returned instruction with its PC+1 and a valid bit to form the IF output toward decode.
- It absorbs the memory's 1-cycle read latency, hazard-unit stalls, and branch/jump redirects.
- PC is word-indexed: increment is +1, no byte adder.

Parameters:
ADDR_W, 11, instruction word-address width (2048-word memory)
DATA_W, 32, instruction width
RESET_PC, 0, first address fetched after reset

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold request from hazard detection unit
branch_taken  in  1  resolved branch redirect
branch_target  in  ADDR_W  branch destination word address
jump  in  1  jump redirect
jump_target  in  ADDR_W  jump destination word address
inst_addr  out  ADDR_W  address to instruction memory (combinational)
inst_in  in  DATA_W  instruction memory read data; reflects inst_addr of previous cycle
if_inst  out  DATA_W  fetched instruction (passthrough of inst_in)
if_pc_next  out  ADDR_W  word address of if_inst plus 1, wrapping
if_valid  out  1  if_inst is a correct-path instruction

Behaviour:
- State registers:
  - pc_q: next address to issue.
  - issued_pc_q: address whose data is on inst_in this cycle.
  - valid_q: drives if_valid.
- Reset takes priority over everything. On the edge with reset=1: pc_q<=RESET_PC, issued_pc_q<=RESET_PC, valid_q<=0. stall and redirects are ignored.
  - While reset=1: inst_addr=RESET_PC, if_valid=0.
  - Reset mid-operation discards all in-flight state identically.
- Priority per cycle: reset > branch_taken > jump > stall > sequential.
- Sequential (no stall, no redirect):
  - inst_addr=pc_q.
  - Edge: issued_pc_q<=pc_q, valid_q<=1, pc_q<=pc_q+1.
  - Increment is modulo 2^ADDR_W: 2047 wraps to 0.
- Stall (no redirect):
  - inst_addr=issued_pc_q, so the memory re-reads the currently presented word and if_inst stays stable.
  - pc_q, issued_pc_q and valid_q hold.
  - Stalling while if_valid=0 keeps it 0.
- Redirect (branch_taken or jump; branch_taken wins if both):
  - inst_addr=pc_q (wrong-path read; result discarded).
  - Edge: pc_q<=target, valid_q<=0. issued_pc_q is don't-care; implement as hold.
  - Next cycle, the sequential rule issues the target.
  - Redirect overrides stall in the same cycle.
- Redirect timing: if_valid=0 for exactly one cycle (R+1). The target instruction appears with if_valid=1 at R+2, absent further stall or redirect.
- Output mapping: if_inst=inst_in, if_pc_next=issued_pc_q+1 (wrapping), if_valid=valid_q.
- Latency:
  - First valid instruction appears 2 cycles after reset deasserts.
  - Steady-state throughput is 1 instruction/cycle.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetched (32b) and perf_bubbles (32b).
  - perf_fetched increments on every edge where if_valid=1 and stall=0.
  - perf_bubbles increments on every edge where if_valid=0 and reset=0.
  - Both counters are cleared by reset and wrap at 2^32.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - ADDR_W and DATA_W defaults;
  - RESET_PC;
  - NOP_INST=32'h0;
  - the address type of width ADDR_W.
- One natural sub-module, fetch_pc_sel: purely combinational. It takes pc_q, issued_pc_q, stall, branch_taken, branch_target, jump and jump_target. It produces inst_addr and the pc_q next-value per the priority order above.
- fetch_unit keeps all registers.

Test Plan:
- Reset held 3 cycles then released, memory preloaded mem[i]=i:
  - inst_addr=0 during reset.
  - if_valid=0 for the first cycle after release.
  - Then if_inst=0,1,2,… with if_pc_next=1,2,3,… one per cycle.
- Stall asserted 3 cycles while if_inst=5:
  - inst_addr=5 during the stall; if_inst stays 5 and if_pc_next stays 6.
  - After release the sequence continues 6,7 with no skip or duplicate.
- branch_taken=1, branch_target=100 for one cycle at cycle R:
  - if_valid=0 at R+1.
  - At R+2: if_inst=100, if_pc_next=101, if_valid=1.
- branch_taken and jump both asserted in the same cycle, branch_target=40, jump_target=80:
  - Fetch resumes at 40.
- branch_taken and stall asserted together, branch_target=7:
  - Redirect wins; at R+2 if_inst=7 and if_valid=1.
- Sequential fetch from pc_q=2046:
  - if_inst=2046 then 2047 then 0; if_pc_next=2047, 0, 1.
- Reset pulsed during a stall following a redirect:
  - Next-cycle state matches power-on.
  - With FETCH_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, reset
// vector, NOP encoding and the word-address type.
package fetch_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 11'd0;
    localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0000;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC / memory-address selection for the fetch stage.
// Priority: branch_taken > jump > stall > sequential increment.
module fetch_pc_sel
    import fetch_pkg::*;
#(
    parameter int ADDR_W = fetch_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] pc_q,
    input  logic [ADDR_W-1:0] issued_pc_q,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [ADDR_W-1:0] pc_d
);

    // Redirects still present pc_q to memory; that wrong-path read is dropped.
    always_comb begin
        inst_addr = pc_q;
        pc_d      = pc_q + ADDR_W'(1);
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (jump) begin
            pc_d = jump_target;
        end else if (stall) begin
            inst_addr = issued_pc_q;
            pc_d      = pc_q;
        end else begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, absorbs 1-cycle memory latency, stalls
// and redirects. Define FETCH_PERF_CNT_EN to add fetched/bubble counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = fetch_pkg::ADDR_W,
    parameter int              DATA_W   = fetch_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_in,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc_next,
    output logic              if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              redirect;

    assign redirect = branch_taken | jump;

    fetch_pc_sel #(.ADDR_W(ADDR_W)) u_pc_sel (
        .pc_q          (pc_q),
        .issued_pc_q   (issued_pc_q),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .inst_addr     (sel_addr),
        .pc_d          (pc_d)
    );

    // Track which address is on inst_in and whether it is correct-path.
    always_comb begin
        issued_pc_d = issued_pc_q;
        valid_d     = valid_q;
        if (redirect) begin
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else begin
            issued_pc_d = pc_q;
            valid_d     = 1'b1;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= RESET_PC;
            valid_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            valid_q     <= valid_d;
        end
    end

    assign inst_addr  = reset ? RESET_PC : sel_addr;
    assign if_inst    = inst_in;
    assign if_pc_next = issued_pc_q + ADDR_W'(1);
    assign if_valid   = valid_q & ~reset;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] bubbles_q, bubbles_d;

    // Counter next-state: delivered instructions vs. empty cycles.
    always_comb begin
        fetched_d = fetched_q;
        bubbles_d = bubbles_q;
        if (if_valid && !stall) begin
            fetched_d = fetched_q + 32'd1;
        end else begin
            fetched_d = fetched_q;
        end
        if (!if_valid) begin
            bubbles_d = bubbles_q + 32'd1;
        end else begin
            bubbles_d = bubbles_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetched_q <= 32'd0;
            bubbles_q <= 32'd0;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a delivery-order model;
// builds with or without FETCH_PERF_CNT_EN.
module tb_fetch_unit;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 2048;

    logic          clock;
    logic          reset;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_in;
    logic [DW-1:0] if_inst;
    logic [AW-1:0] if_pc_next;
    logic          if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_bubbles;
`endif

    fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .inst_addr     (inst_addr),
        .inst_in       (inst_in),
        .if_inst       (if_inst),
        .if_pc_next    (if_pc_next),
        .if_valid      (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous instruction memory, preloaded with mem[i] = i.
    logic [DW-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = i;
    always @(posedge clock) inst_in <= mem[inst_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference model: what the stage should be delivering, in instruction terms.
    int          m_next;    // next correct-path address to be fetched
    int          m_cur;     // address of the word memory is presenting
    bit          m_valid;   // presented word is correct-path
    int unsigned m_fetched;
    int unsigned m_bubbles;

    task automatic step(input bit rst, input bit st, input bit bt, input int btgt,
                        input bit jp, input int jtgt);
        int exp_addr;
        @(negedge clock);
        reset         = rst;
        stall         = st;
        branch_taken  = bt;
        branch_target = AW'(btgt);
        jump          = jp;
        jump_target   = AW'(jtgt);
        #1;
        if (rst)            exp_addr = 0;
        else if (bt || jp)  exp_addr = m_next;
        else if (st)        exp_addr = m_cur;
        else                exp_addr = m_next;
        check_val("inst_addr", 32'(inst_addr), 32'(exp_addr));
        check_val("if_valid", 32'(if_valid), rst ? 32'd0 : 32'(m_valid));
        if (!rst && m_valid) begin
            check_val("if_inst", if_inst, mem[m_cur]);
            check_val("if_pc_next", 32'(if_pc_next), 32'((m_cur + 1) % DEPTH));
        end
`ifdef FETCH_PERF_CNT_EN
        if (!rst) begin
            check_val("perf_fetched", perf_fetched, m_fetched);
            check_val("perf_bubbles", perf_bubbles, m_bubbles);
        end
`endif
        @(posedge clock);
        if (rst) begin
            m_next = 0; m_cur = 0; m_valid = 1'b0;
            m_fetched = 0; m_bubbles = 0;
        end else begin
            if (m_valid && !st) m_fetched++;
            if (!m_valid)       m_bubbles++;
            if (bt) begin
                m_next = btgt; m_valid = 1'b0;
            end else if (jp) begin
                m_next = jtgt; m_valid = 1'b0;
            end else if (!st) begin
                m_cur = m_next; m_next = (m_next + 1) % DEPTH; m_valid = 1'b1;
            end
        end
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        m_next = 0; m_cur = 0; m_valid = 1'b0; m_fetched = 0; m_bubbles = 0;

        // Reset for 3 cycles, then sequential fetch up to instruction 5.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        seq(7);
        check_val("seq_at_5", if_inst, 32'd5);
        // Hold on instruction 5 for three cycles, then continue.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
        seq(3);

        // Branch to 100, simultaneous branch/jump, branch under stall.
        step(1'b0, 1'b0, 1'b1, 100, 1'b0, 0);
        seq(3);
        step(1'b0, 1'b0, 1'b1, 40, 1'b1, 80);
        seq(3);
        step(1'b0, 1'b1, 1'b1, 7, 1'b0, 0);
        seq(2);

        // Wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 2046);
        seq(5);

        // Reset pulsed during a stall that follows a redirect.
        step(1'b0, 1'b0, 1'b1, 300, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        seq(4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 7), int'($urandom_range(0, DEPTH - 1)),
                 ($urandom_range(0, 99) < 7), int'($urandom_range(0, DEPTH - 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
